eager_fork: RTL and testbench

EAGER_FORK -- requirements
Module: eager_fork

---
 rtl/eager_fork.sv | 70 +++++++
 tb/tb_eager_fork.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/eager_fork.sv
`default_nettype none
// ============================================================================
// Module      : eager_fork
// Description : Splits one valid/ready token stream into NUM_OUTPUTS branches.
//               Eager mode lets each branch accept on its own. Lazy mode hands
//               the token over only when every enabled branch is ready at once.
// Revision    : 1.0 - initial release
// ============================================================================
module eager_fork #(
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_OUTPUTS-1:0] fork_mask_i,
    input  logic                   eager_en_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [NUM_OUTPUTS-1:0] valids_o,
    input  logic [NUM_OUTPUTS-1:0] readys_i,
    output logic [NUM_OUTPUTS-1:0] sent_o
);

    logic [NUM_OUTPUTS-1:0] r_sent_q;
    logic [NUM_OUTPUTS-1:0] w_lazy_ok;
    logic [NUM_OUTPUTS-1:0] w_eager_ok;
    logic [NUM_OUTPUTS-1:0] w_lazy_valids;
    logic [NUM_OUTPUTS-1:0] w_eager_valids;
    logic [NUM_OUTPUTS-1:0] w_valids;
    logic                   w_ready;

    // A branch does not block the token if it is disabled, already served or ready now
    assign w_lazy_ok      = ~fork_mask_i | readys_i;
    assign w_eager_ok     = ~fork_mask_i | r_sent_q | readys_i;
    assign w_eager_valids = {NUM_OUTPUTS{valid_i}} & fork_mask_i & ~r_sent_q;

    generate
        for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_lazy_valid
            // Own bit forced high so valids_o[i] never looks at readys_i[i]
            localparam logic [NUM_OUTPUTS-1:0] c_self_bit = NUM_OUTPUTS'(1) << i;
            assign w_lazy_valids[i] = valid_i & fork_mask_i[i] & (&(w_lazy_ok | c_self_bit));
        end
    endgenerate

    assign w_valids = eager_en_i ? w_eager_valids : w_lazy_valids;
    assign w_ready  = eager_en_i ? (&w_eager_ok) : (&w_lazy_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sent_q <= '0;
        end else if (!eager_en_i) begin
            r_sent_q <= '0;
        end else if (valid_i) begin
            if (w_ready) begin
                r_sent_q <= '0;
            end else begin
                r_sent_q <= r_sent_q | (w_valids & readys_i);
            end
        end
    end

    assign data_o   = data_i;
    assign valids_o = w_valids;
    assign ready_o  = w_ready;
    assign sent_o   = r_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_eager_fork.sv
`default_nettype none
// ============================================================================
// Module      : tb_eager_fork
// Description : Self-checking bench for eager_fork at 2, 3 and 4 branches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eager_fork;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- N=2 instance ----------------
    logic       rst2_n = 1'b1;
    logic [1:0] mask2, rdy2, val2, sent2;
    logic       eager2, valid2, ready2;
    logic [7:0] din2, dout2;

    eager_fork #(.NUM_OUTPUTS(2), .DATA_WIDTH(8)) u2 (
        .clk_i(clk), .rst_ni(rst2_n), .fork_mask_i(mask2), .eager_en_i(eager2),
        .data_i(din2), .valid_i(valid2), .ready_o(ready2), .data_o(dout2),
        .valids_o(val2), .readys_i(rdy2), .sent_o(sent2)
    );

    // ---------------- N=3 instance ----------------
    logic       rst3_n = 1'b1;
    logic [2:0] mask3, rdy3, val3, sent3;
    logic       eager3, valid3, ready3;
    logic [7:0] din3, dout3;

    eager_fork #(.NUM_OUTPUTS(3), .DATA_WIDTH(8)) u3 (
        .clk_i(clk), .rst_ni(rst3_n), .fork_mask_i(mask3), .eager_en_i(eager3),
        .data_i(din3), .valid_i(valid3), .ready_o(ready3), .data_o(dout3),
        .valids_o(val3), .readys_i(rdy3), .sent_o(sent3)
    );

    // ---------------- N=4 instance ----------------
    logic        rst4_n = 1'b1;
    logic [3:0]  mask4, rdy4, val4, sent4;
    logic        eager4, valid4, ready4;
    logic [15:0] din4, dout4;

    eager_fork #(.NUM_OUTPUTS(4), .DATA_WIDTH(16)) u4 (
        .clk_i(clk), .rst_ni(rst4_n), .fork_mask_i(mask4), .eager_en_i(eager4),
        .data_i(din4), .valid_i(valid4), .ready_o(ready4), .data_o(dout4),
        .valids_o(val4), .readys_i(rdy4), .sent_o(sent4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic       eager;
        logic [1:0] mask;
        logic       valid;
        logic [1:0] rdy;
        logic [1:0] exp_val;
        logic       exp_rdy;
        logic [1:0] exp_sent;
    } vec_t;

    vec_t        tbl [14];
    logic [15:0] sbq [4][$];

    initial begin
        logic [3:0]  m;
        logic [15:0] d;
        logic [15:0] exp_d;
        logic        done;
        int          cyc;

        // eager, mask, valid, readys -> valids, ready, sent after the edge
        tbl[0]  = '{1'b1, 2'b11, 1'b1, 2'b11, 2'b11, 1'b1, 2'b00};
        tbl[1]  = '{1'b1, 2'b11, 1'b1, 2'b01, 2'b11, 1'b0, 2'b01};
        tbl[2]  = '{1'b1, 2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 2'b00};
        tbl[3]  = '{1'b0, 2'b11, 1'b1, 2'b01, 2'b10, 1'b0, 2'b00};
        tbl[4]  = '{1'b0, 2'b11, 1'b1, 2'b10, 2'b01, 1'b0, 2'b00};
        tbl[5]  = '{1'b0, 2'b11, 1'b1, 2'b11, 2'b11, 1'b1, 2'b00};
        tbl[6]  = '{1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 2'b00};
        tbl[7]  = '{1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00};
        tbl[8]  = '{1'b1, 2'b11, 1'b1, 2'b10, 2'b11, 1'b0, 2'b10};
        tbl[9]  = '{1'b1, 2'b11, 1'b0, 2'b11, 2'b00, 1'b1, 2'b10};
        tbl[10] = '{1'b1, 2'b11, 1'b1, 2'b00, 2'b01, 1'b0, 2'b10};
        tbl[11] = '{1'b1, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1, 2'b00};
        tbl[12] = '{1'b1, 2'b11, 1'b1, 2'b01, 2'b11, 1'b0, 2'b01};
        tbl[13] = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00};

        eager2 = 1'b1; mask2 = 2'b11; valid2 = 1'b1; rdy2 = 2'b00; din2 = 8'h00;
        eager3 = 1'b1; mask3 = 3'b111; valid3 = 1'b0; rdy3 = 3'b000; din3 = 8'h00;
        eager4 = 1'b1; mask4 = 4'b0000; valid4 = 1'b0; rdy4 = 4'b0000; din4 = 16'h0;
        rst2_n = 1'b0; rst3_n = 1'b0; rst4_n = 1'b0;

        // Reset state: outputs follow eager equations with empty sent register
        #2;
        chk("reset_sent2", 32'(sent2), 32'h0);
        chk("reset_valids2", 32'(val2), 32'h3);
        chk("reset_ready2", 32'(ready2), 32'h0);
        chk("reset_sent3", 32'(sent3), 32'h0);
        @(posedge clk); #1;
        rst2_n = 1'b1; rst3_n = 1'b1; rst4_n = 1'b1;

        // Table-driven sequence on the N=2 instance
        for (int i = 0; i < 14; i++) begin
            eager2 = tbl[i].eager; mask2 = tbl[i].mask;
            valid2 = tbl[i].valid; rdy2 = tbl[i].rdy;
            din2 = 8'h30 + 8'(i);
            @(negedge clk);
            chk($sformatf("row%0d_valids", i), 32'(val2), 32'(tbl[i].exp_val));
            chk($sformatf("row%0d_ready", i), 32'(ready2), 32'(tbl[i].exp_rdy));
            chk($sformatf("row%0d_data", i), 32'(dout2), 32'h30 + 32'(i));
            @(posedge clk); #1;
            chk($sformatf("row%0d_sent", i), 32'(sent2), 32'(tbl[i].exp_sent));
        end
        valid2 = 1'b0;

        // Asynchronous reset mid-token on the N=3 instance
        valid3 = 1'b1; din3 = 8'h5A; rdy3 = 3'b011;
        @(posedge clk); #1;
        chk("n3_sent_partial", 32'(sent3), 32'h3);
        rdy3 = 3'b000;
        #1 rst3_n = 1'b0;
        #1;
        chk("n3_sent_in_reset", 32'(sent3), 32'h0);
        chk("n3_valids_in_reset", 32'(val3), 32'h7);
        #1 rst3_n = 1'b1;
        @(negedge clk);
        chk("n3_valids_reoffer", 32'(val3), 32'h7);
        chk("n3_ready_blocked", 32'(ready3), 32'h0);
        rdy3 = 3'b111;
        #1;
        chk("n3_ready_all", 32'(ready3), 32'h1);
        @(posedge clk); #1;
        chk("n3_sent_done", 32'(sent3), 32'h0);
        valid3 = 1'b0;

        // Empty mask on the N=4 instance drops the token at once
        valid4 = 1'b1; mask4 = 4'b0000; rdy4 = 4'b1010; din4 = 16'hBEEF;
        @(negedge clk);
        chk("n4_zero_mask_ready", 32'(ready4), 32'h1);
        chk("n4_zero_mask_valids", 32'(val4), 32'h0);
        @(posedge clk); #1;
        chk("n4_zero_mask_sent", 32'(sent4), 32'h0);

        // Random tokens with per-branch scoreboard, eager then lazy
        for (int t = 0; t < 1000; t++) begin
            m = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            eager4 = (t < 500); mask4 = m; din4 = d; valid4 = 1'b1;
            for (int b = 0; b < 4; b++) if (m[b]) sbq[b].push_back(d);
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 200) begin
                rdy4 = 4'($urandom_range(0, 15));
                @(negedge clk);
                chk("rand_unmasked_valid", 32'(val4 & ~m), 32'h0);
                for (int b = 0; b < 4; b++) begin
                    if (val4[b] && rdy4[b]) begin
                        if (sbq[b].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rand_dup branch=%0d actual=%0h required=none", b, dout4);
                        end else begin
                            exp_d = sbq[b].pop_front();
                            chk($sformatf("rand_data_b%0d", b), 32'(dout4), 32'(exp_d));
                        end
                    end
                end
                done = ready4;
                @(posedge clk); #1;
                cyc++;
            end
            chk("rand_token_done", 32'(done), 32'h1);
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("rand_left_b%0d", b), 32'(sbq[b].size()), 32'h0);
                sbq[b].delete();
            end
            chk("rand_sent_cleared", 32'(sent4), 32'h0);
        end
        valid4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
